// File: rtl/uart_rx.sv
// 8-bit UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx #(
  parameter int BAUD_RATE      = 115_200,
  parameter int EXTERNAL_CLOCK = 50_000_000
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic [2:0] state_dbg_o
);

  localparam int CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  // Encoding is visible on state_dbg_o: IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 WAIT_IDLE=5.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;
  logic          mid_bit;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign rx_s    = sync2_q;
  assign mid_bit = (cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      sync1_q    <= data_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit still low at its centre is real; otherwise it was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (mid_bit) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_bit) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (mid_bit) begin
          cnt_d      = '0;
          data_out_d = shift_q;
          valid_d    = 1'b1;
          ferr_d     = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d     = par_q ^ (^shift_q);
`endif
          state_d    = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out     = data_out_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign state_dbg_o  = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate in bits/s.
REQ-002 SHALL have parameter EXTERNAL_CLOCK, default 50_000_000, meaning clk frequency in Hz.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port async_nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port data_out  output  8  last received byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse, data_out holds a new byte.
REQ-008 SHALL have port parity_error  output  1  qualified by data_valid; received parity bit mismatch.
REQ-009 SHALL have port frame_error  output  1  qualified by data_valid; stop bit sampled low.

Function
REQ-010 SHALL pass data_in through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-011 SHALL derive CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE (integer division, 434 at defaults) and HALF_BIT = CLKS_PER_BIT / 2 (217).
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 SHALL leave IDLE for START on the first cycle rx_s is 0, clearing the bit-time counter.
REQ-014 SHALL, in START, sample rx_s after HALF_BIT cycles: 0 -> DATA with counter reset; 1 -> IDLE (glitch reject, no pulse, no error).
REQ-015 SHALL, in DATA, sample rx_s every CLKS_PER_BIT cycles (mid-bit), shifting bits LSB first; after bit 7 go to PARITY.
REQ-016 SHALL, in PARITY, sample the bit at mid-bit; parity_error = sampled bit XOR (XOR of the 8 data bits) (even parity); then go to STOP.
REQ-017 SHALL, in STOP, sample rx_s at mid-bit; next cycle load data_out, drive data_valid=1 for exactly one cycle with parity_error and frame_error.
REQ-018 SHALL go STOP -> IDLE when stop bit is 1, enabling back-to-back frames with no idle gap.
REQ-019 SHALL go STOP -> WAIT_IDLE when stop bit is 0 (frame_error=1), and WAIT_IDLE -> IDLE only on the first cycle rx_s is 1.
REQ-020 SHALL hold data_out stable between data_valid pulses; parity_error and frame_error are 0 whenever data_valid is 0.
REQ-021 SHALL ignore rx_s transitions outside the mid-bit sample points while not in IDLE/WAIT_IDLE.

Reset
REQ-022 SHALL, on async_nreset low, immediately force state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, data_valid 0, parity_error 0, frame_error 0.
REQ-023 SHALL abandon any frame in progress when reset asserts mid-frame, emitting no data_valid for it.
REQ-024 SHALL, after reset release with data_in low, treat the low as a start edge (START entered, validated at HALF_BIT).

Configuration
REQ-025 SHALL, with macro UART_RX_PARITY_EN defined, expect the frame start, 8 data, parity, stop and check parity per REQ-016.
REQ-026 SHALL, without UART_RX_PARITY_EN, expect start, 8 data, stop; DATA goes directly to STOP, parity_error tied 0.

Verification
REQ-027 SHALL cover: parity on, send 8'hBD frame (0,1,0,1,1,1,1,0,1,parity 0,stop 1) at 434 clk/bit -> one data_valid, data_out=8'hBD, both errors 0.
REQ-028 SHALL cover: parity on, 8'hBD with parity bit 1 -> data_valid, data_out=8'hBD, parity_error=1, frame_error=0.
REQ-029 SHALL cover: 8'h55 with stop bit 0, line held low 2000 cycles then high -> data_valid with frame_error=1, no second pulse until a new valid start after line high.
REQ-030 SHALL cover: 100-cycle low glitch on idle line -> no data_valid, state back to IDLE.
REQ-031 SHALL cover: back-to-back frames 8'h00 then 8'hFF with no idle gap -> two pulses, values 8'h00 and 8'hFF, no errors.
REQ-032 SHALL cover: async_nreset low during data bit 4 of a frame -> outputs at reset values immediately, no data_valid for that frame, next clean frame 8'hA5 received correctly.
